// File: rtl/trace_dump.sv
// Streams a finished 2**ADDR_W-entry circular trace, oldest sample first, over valid/ready.
// Latency: 2+RD_LAT cycles per sample when tx_rdy is high; tx_data is held until it is accepted.
module trace_dump #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_req,
    input  logic              abort,
    input  logic              capture_done,
    input  logic [ADDR_W-1:0] trace_end,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_vld,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              dump_done,
    output logic              nak,
    output logic              clr_capture_done
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, SEND, DONE} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        ram_en           = 1'b0;
        tx_vld           = 1'b0;
        dump_done        = 1'b0;
        clr_capture_done = 1'b0;
        busy             = (state != IDLE);
        case (state)
            IDLE: if (dump_req && capture_done) state_nxt = RD;
            RD: begin
                ram_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (lat == 2'd1) state_nxt = SEND;
            SEND: begin
                tx_vld = 1'b1;
                if (tx_rdy) state_nxt = (cnt == '1) ? DONE : RD;
            end
            DONE: begin
                dump_done        = 1'b1;
                clr_capture_done = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // abort beats a same-cycle handshake so the trace stays intact for a retry
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            cnt      <= '0;
            lat      <= '0;
            tx_data  <= '0;
            nak      <= 1'b0;
        end else begin
            nak <= (state == IDLE) && dump_req && !capture_done;
            case (state)
                IDLE: if (dump_req && capture_done) begin
                    ram_addr <= trace_end + 1'b1;
                    cnt      <= '0;
                end
                RD: lat <= LAT_INIT;
                WAIT: begin
                    lat <= lat - 1'b1;
                    if (lat == 2'd1) tx_data <= ram_rdata;
                end
                SEND: if (tx_rdy && !abort && cnt != '1) begin
                    cnt      <= cnt + 1'b1;
                    ram_addr <= ram_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_dump.sv
// Directed sequence with random RAM contents/backpressure, checked against a queue-based model.
module tb_trace_dump;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dump_req = 1'b0, abort = 1'b0, capture_done = 1'b1;
    logic [8:0] trace_end = '0;
    logic       tx_rdy = 1'b1;
    logic       rdy_rand = 1'b0;

    logic [8:0] ram_addr;
    logic       ram_en, tx_vld, busy, dump_done, nak, clr_capture_done;
    logic [7:0] ram_rdata, tx_data;

    logic       dump_req3 = 1'b0;
    logic [8:0] ram_addr3;
    logic       ram_en3, tx_vld3, busy3, dump_done3, nak3, clr3;
    logic [7:0] ram_rdata3, tx_data3;

    logic [7:0] mem [512];
    logic [7:0] p3 [3];
    logic [7:0] exp_q[$], got[$], got3[$];
    logic [8:0] addrs[$];
    int checks = 0, errors = 0, cyc = 0, t0 = 0;
    int done_cnt = 0, clr_cnt = 0, nak_cnt = 0, done_cyc = 0;
    int done3_cnt = 0, clr3_cnt = 0, done3_cyc = 0;
    logic stall = 1'b0;
    logic [7:0] held = '0;

    trace_dump #(.ADDR_W(9), .DATA_W(8), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .abort(abort),
        .capture_done(capture_done), .trace_end(trace_end), .ram_addr(ram_addr),
        .ram_en(ram_en), .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_vld(tx_vld),
        .tx_rdy(tx_rdy), .busy(busy), .dump_done(dump_done), .nak(nak),
        .clr_capture_done(clr_capture_done));

    trace_dump #(.ADDR_W(9), .DATA_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .dump_req(dump_req3), .abort(1'b0),
        .capture_done(capture_done), .trace_end(trace_end), .ram_addr(ram_addr3),
        .ram_en(ram_en3), .ram_rdata(ram_rdata3), .tx_data(tx_data3), .tx_vld(tx_vld3),
        .tx_rdy(1'b1), .busy(busy3), .dump_done(dump_done3), .nak(nak3),
        .clr_capture_done(clr3));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: unread cycles return X so a mistimed capture is visible
    always @(posedge clk) ram_rdata <= ram_en ? mem[ram_addr] : 8'hxx;
    always @(posedge clk) begin
        p3[0] <= ram_en3 ? mem[ram_addr3] : 8'hxx;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram_rdata3 = p3[2];

    initial forever begin
        @(posedge clk);
        #1;
        tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (ram_en) addrs.push_back(ram_addr);
        if (tx_vld && tx_rdy && !abort) got.push_back(tx_data);
        if (dump_done) begin done_cnt++; done_cyc = cyc; end
        if (clr_capture_done) clr_cnt++;
        if (nak) nak_cnt++;
        if (dump_done || clr_capture_done) check("done_with_clr", clr_capture_done, dump_done);
        if (stall) begin
            check("hold_vld", tx_vld, 1);
            check("hold_dat", tx_data, held);
        end
        stall = tx_vld && !tx_rdy && !abort;
        held  = tx_data;
        if (tx_vld3) got3.push_back(tx_data3);
        if (dump_done3) begin done3_cnt++; done3_cyc = cyc; end
        if (clr3) clr3_cnt++;
    end

    task automatic build_exp(input logic [8:0] te);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(mem[9'(te + 1 + i)]);
    endtask

    task automatic compare(input string tag, input logic [7:0] q[$]);
        int bad = 0;
        check({tag, "_count"}, q.size(), 512);
        for (int i = 0; i < q.size() && i < exp_q.size(); i++)
            if (q[i] !== exp_q[i]) bad++;
        check({tag, "_data"}, bad, 0);
    endtask

    task automatic start1(input logic [8:0] te);
        @(posedge clk);
        #1;
        got.delete(); addrs.delete();
        done_cnt = 0; clr_cnt = 0; nak_cnt = 0;
        trace_end = te;
        dump_req  = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        dump_req = 1'b0;
    endtask

    task automatic wait_done1(input int lim);
        for (int i = 0; i < lim && done_cnt == 0; i++) @(negedge clk);
        check("done_seen", done_cnt != 0, 1);
        repeat (4) @(negedge clk);
    endtask

    logic [8:0] te;
    logic       found;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        #12;
        check("rst_busy", busy, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_tx_vld", tx_vld, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_outs", {dump_done, nak, clr_capture_done}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // address-pattern RAM, oldest sample at 0x100
        start1(9'h0FF);
        wait_done1(2000);
        check("full_cycles", done_cyc - t0, 1537);
        build_exp(9'h0FF);
        compare("pattern", got);
        check("first_byte", got[0], 8'h00);
        check("last_byte", got[511], 8'hFF);
        check("first_addr", addrs[0], 9'h100);
        check("last_addr", addrs[511], 9'h0FF);
        check("reads", addrs.size(), 512);
        check("done_pulses", done_cnt, 1);
        check("clr_pulses", clr_cnt, 1);
        check("idle_after", busy, 0);

        // wrap at trace_end=0x1FF; trace_end and capture_done change mid-dump
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        start1(9'h1FF);
        repeat (20) @(posedge clk);
        trace_end = 9'($urandom);
        capture_done = 1'b0;
        wait_done1(2000);
        capture_done = 1'b1;
        build_exp(9'h1FF);
        compare("wrap", got);
        check("wrap_first_addr", addrs[0], 9'h000);
        check("wrap_last_addr", addrs[511], 9'h1FF);

        // random backpressure plus an ignored dump_req while busy
        te = 9'($urandom);
        rdy_rand = 1'b1;
        start1(te);
        repeat (50) @(posedge clk);
        #1 dump_req = 1'b1;
        @(posedge clk);
        #1 dump_req = 1'b0;
        wait_done1(8000);
        rdy_rand = 1'b0;
        build_exp(te);
        compare("backpressure", got);
        check("busy_req_no_nak", nak_cnt, 0);
        check("bp_done_pulses", done_cnt, 1);

        // refused request
        capture_done = 1'b0;
        @(posedge clk);
        #1 dump_req = 1'b1;
        @(posedge clk);
        #1 dump_req = 1'b0;
        check("nak_pulse", nak, 1);
        check("nak_busy", busy, 0);
        check("nak_ram_en", ram_en, 0);
        check("nak_tx_vld", tx_vld, 0);
        @(posedge clk);
        #1;
        check("nak_single", nak, 0);
        check("nak_still_idle", {busy, ram_en, tx_vld}, 0);
        capture_done = 1'b1;

        // abort in SEND after 100 accepted bytes, then retry
        te = 9'($urandom);
        start1(te);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (tx_vld && tx_rdy && got.size() == 100) found = 1'b1;
        end
        check("abort_point_found", found, 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_tx_vld", tx_vld, 0);
        check("abort_ram_en", ram_en, 0);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_clr", clr_cnt, 0);
        check("abort_bytes", got.size(), 100);
        start1(te);
        wait_done1(2000);
        build_exp(te);
        compare("retry", got);
        check("retry_first_addr", addrs[0], 9'(te + 1));

        // RD_LAT=3 instance: 5 cycles per sample
        te = 9'($urandom);
        trace_end = te;
        got3.delete(); done3_cnt = 0; clr3_cnt = 0;
        @(posedge clk);
        #1 dump_req3 = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 dump_req3 = 1'b0;
        for (int i = 0; i < 4000 && done3_cnt == 0; i++) @(negedge clk);
        check("lat3_done_seen", done3_cnt, 1);
        check("lat3_cycles", done3_cyc - t0, 5 * 512 + 1);
        build_exp(te);
        compare("lat3", got3);

        // asynchronous reset mid-dump
        clr3_cnt = 0;
        @(posedge clk);
        #1 dump_req3 = 1'b1;
        @(posedge clk);
        #1 dump_req3 = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("lat3_busy_before_rst", busy3, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy3, 0);
        check("rst_mid_tx_vld", tx_vld3, 0);
        check("rst_mid_ram_en", ram_en3, 0);
        check("rst_mid_ram_addr", ram_addr3, 0);
        check("rst_mid_tx_data", tx_data3, 0);
        check("rst_mid_pulses", {dump_done3, nak3, clr3}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_clr", clr3_cnt, 0);
        check("rst_stays_idle", busy3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
